// File: rtl/mem_lsq_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsq_if
// Brief   : Dispatch, AGU, data-cache and CDB signal bundle of the load/store
//           queue. The slave modport is the queue's view of the bundle.
// Rev     : 1.0 - initial release
// ============================================================================
interface mem_lsq_if #(
    parameter int ROB_IDX = 5,
    parameter int PRF_IDX = 6
) ();
    logic               flush;
    logic               ds_valid;
    logic               ds_ready;
    logic               ds_is_store;
    logic [2:0]         ds_funct3;
    logic [ROB_IDX-1:0] ds_rob_id;
    logic [PRF_IDX-1:0] ds_rd_phy;
    logic               agu_valid;
    logic [ROB_IDX-1:0] agu_rob_id;
    logic [31:0]        agu_addr;
    logic [31:0]        agu_wdata;
    logic [ROB_IDX-1:0] rob_head_id;
    logic [31:0]        dmem_addr;
    logic [3:0]         dmem_rmask;
    logic [3:0]         dmem_wmask;
    logic [31:0]        dmem_wdata;
    logic [31:0]        dmem_rdata;
    logic               dmem_resp;
    logic               cdb_valid;
    logic [ROB_IDX-1:0] cdb_rob_id;
    logic [PRF_IDX-1:0] cdb_rd_phy;
    logic [31:0]        cdb_rd_value;

    modport master (
        output flush, ds_valid, ds_is_store, ds_funct3, ds_rob_id, ds_rd_phy,
               agu_valid, agu_rob_id, agu_addr, agu_wdata, rob_head_id,
               dmem_rdata, dmem_resp,
        input  ds_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_value
    );

    modport slave (
        input  flush, ds_valid, ds_is_store, ds_funct3, ds_rob_id, ds_rd_phy,
               agu_valid, agu_rob_id, agu_addr, agu_wdata, rob_head_id,
               dmem_rdata, dmem_resp,
        output ds_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_value
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsq.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsq
// Brief   : In-order unified load/store queue. Allocated at dispatch, filled
//           by AGU results on rob_id, head issues to dmem, results on the CDB.
// Rev     : 1.0 - initial release
// ============================================================================
module mem_lsq #(
    parameter int LSQ_DEPTH = 8,
    parameter int ROB_IDX   = 5,
    parameter int PRF_IDX   = 6
) (
    input logic       clk,
    input logic       rst,
    mem_lsq_if.slave  bus
);
    localparam int LSQ_IDX = $clog2(LSQ_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [LSQ_DEPTH-1:0] r_valid;
    logic [LSQ_DEPTH-1:0] r_addr_valid;
    logic [LSQ_DEPTH-1:0] r_is_store;
    logic [2:0]           r_funct3 [LSQ_DEPTH];
    logic [ROB_IDX-1:0]   r_rob_id [LSQ_DEPTH];
    logic [PRF_IDX-1:0]   r_rd_phy [LSQ_DEPTH];
    logic [31:0]          r_addr   [LSQ_DEPTH];
    logic [31:0]          r_wdata  [LSQ_DEPTH];
    logic [LSQ_IDX:0]     r_head;
    logic [LSQ_IDX:0]     r_tail;
    logic [1:0]           r_state;

    logic [31:0]          r_dmem_addr;
    logic [31:0]          r_dmem_wdata;
    logic [3:0]           r_dmem_rmask;
    logic [3:0]           r_dmem_wmask;
    logic                 r_cdb_valid;
    logic [ROB_IDX-1:0]   r_cdb_rob_id;
    logic [PRF_IDX-1:0]   r_cdb_rd_phy;
    logic [31:0]          r_cdb_rd_value;

    logic [LSQ_IDX-1:0]   w_hidx;
    logic [LSQ_IDX-1:0]   w_tidx;
    logic                 w_full;
    logic                 w_alloc;
    logic                 w_issue;
    logic [1:0]           w_off;
    logic [3:0]           w_mask;
    logic [31:0]          w_shifted;
    logic [31:0]          w_load_value;

    always_comb begin
        w_hidx  = r_head[LSQ_IDX-1:0];
        w_tidx  = r_tail[LSQ_IDX-1:0];
        w_full  = (w_hidx == w_tidx) && (r_head[LSQ_IDX] != r_tail[LSQ_IDX]);
        w_alloc = bus.ds_valid && !w_full && !bus.flush;
        // Stores wait for the ROB head so they are never speculative.
        w_issue = (r_state == c_IDLE) && !bus.flush && r_valid[w_hidx] &&
                  r_addr_valid[w_hidx] &&
                  (!r_is_store[w_hidx] || (bus.rob_head_id == r_rob_id[w_hidx]));
        w_off   = r_addr[w_hidx][1:0];
        case (r_funct3[w_hidx][1:0])
            2'b00:   w_mask = 4'b0001 << w_off;
            2'b01:   w_mask = 4'b0011 << w_off;
            default: w_mask = 4'b1111;
        endcase
        w_shifted = bus.dmem_rdata >> {w_off, 3'b000};
        case (r_funct3[w_hidx])
            3'b000:  w_load_value = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_value = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_value = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_value = {16'd0, w_shifted[15:0]};
            default: w_load_value = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_valid        <= '0;
            r_addr_valid   <= '0;
            r_state        <= c_IDLE;
            r_dmem_addr    <= '0;
            r_dmem_wdata   <= '0;
            r_dmem_rmask   <= '0;
            r_dmem_wmask   <= '0;
            r_cdb_valid    <= 1'b0;
            r_cdb_rob_id   <= '0;
            r_cdb_rd_phy   <= '0;
            r_cdb_rd_value <= '0;
        end else begin
            r_dmem_rmask <= '0;
            r_dmem_wmask <= '0;
            r_cdb_valid  <= 1'b0;

            for (int i = 0; i < LSQ_DEPTH; i++) begin
                if (bus.agu_valid && r_valid[i] && (r_rob_id[i] == bus.agu_rob_id)) begin
                    r_addr[i]       <= bus.agu_addr;
                    r_wdata[i]      <= bus.agu_wdata;
                    r_addr_valid[i] <= 1'b1;
                end
            end

            if (w_alloc) begin
                r_valid[w_tidx]      <= 1'b1;
                r_addr_valid[w_tidx] <= 1'b0;
                r_is_store[w_tidx]   <= bus.ds_is_store;
                r_funct3[w_tidx]     <= bus.ds_funct3;
                r_rob_id[w_tidx]     <= bus.ds_rob_id;
                r_rd_phy[w_tidx]     <= bus.ds_rd_phy;
                r_tail               <= r_tail + 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_issue) begin
                        r_dmem_addr <= {r_addr[w_hidx][31:2], 2'b00};
                        if (r_is_store[w_hidx]) begin
                            r_dmem_wmask <= w_mask;
                            r_dmem_wdata <= r_wdata[w_hidx] << {w_off, 3'b000};
                        end else begin
                            r_dmem_rmask <= w_mask;
                        end
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (bus.dmem_resp) begin
                        r_cdb_valid    <= 1'b1;
                        r_cdb_rob_id   <= r_rob_id[w_hidx];
                        r_cdb_rd_phy   <= r_is_store[w_hidx] ? '0 : r_rd_phy[w_hidx];
                        r_cdb_rd_value <= r_is_store[w_hidx] ? '0 : w_load_value;
                        r_valid[w_hidx]      <= 1'b0;
                        r_addr_valid[w_hidx] <= 1'b0;
                        r_head               <= r_head + 1'b1;
                        r_state              <= c_IDLE;
                    end
                end
                c_DRAIN: begin
                    if (bus.dmem_resp) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            // A request already in flight must still be retired by dmem before
            // the next issue, hence DRAIN instead of IDLE.
            if (bus.flush) begin
                r_head       <= '0;
                r_tail       <= '0;
                r_valid      <= '0;
                r_addr_valid <= '0;
                r_cdb_valid  <= 1'b0;
                r_dmem_rmask <= '0;
                r_dmem_wmask <= '0;
                if (((r_state == c_WAIT) || (r_state == c_DRAIN)) && !bus.dmem_resp) begin
                    r_state <= c_DRAIN;
                end else begin
                    r_state <= c_IDLE;
                end
            end
        end
    end

    assign bus.ds_ready     = !w_full;
    assign bus.dmem_addr    = r_dmem_addr;
    assign bus.dmem_rmask   = r_dmem_rmask;
    assign bus.dmem_wmask   = r_dmem_wmask;
    assign bus.dmem_wdata   = r_dmem_wdata;
    assign bus.cdb_valid    = r_cdb_valid;
    assign bus.cdb_rob_id   = r_cdb_rob_id;
    assign bus.cdb_rd_phy   = r_cdb_rd_phy;
    assign bus.cdb_rd_value = r_cdb_rd_value;
endmodule
`default_nettype wire
